// File: rtl/hamsa_l0_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : hamsa_l0_pkg                                                 |
// | Description : Shared L0 line-cache definitions. It holds the line and beat |
// |               geometry, the refill FSM state encoding and the line address |
// |               split. The L0 cache uses the same package, so both agree on  |
// |               tag/index/offset.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hamsa_l0_pkg;

   localparam int LINE_W     = 128;
   localparam int BEAT_W     = 32;
   localparam int BEATS      = 4;
   localparam int BEAT_IDX_W = 2;
   localparam int OFFSET_W   = 4;
   localparam int IDX_W      = 6;
   localparam int TAG_W      = 32 - IDX_W - OFFSET_W;

   // Refill FSM encoding. Plain constants keep the encoding visible to
   // legacy tooling that cannot see enum types.
   typedef logic [2:0] refill_state_e;
   localparam refill_state_e S_IDLE     = 3'd0;
   localparam refill_state_e S_REQ      = 3'd1;
   localparam refill_state_e S_WAIT_R   = 3'd2;
   localparam refill_state_e S_WRITE    = 3'd3;
   localparam refill_state_e S_PF_SETUP = 3'd4;
   localparam refill_state_e S_DRAIN    = 3'd5;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [IDX_W-1:0]    idx;
      logic [OFFSET_W-1:0] offset;
   } l0_line_addr_t;

   // Byte address -> 16-byte-aligned line base.
   function automatic logic [31:0] line_base_of(input logic [31:0] addr);
      l0_line_addr_t a;
      a        = addr;
      a.offset = '0;
      return a;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hamsa_l0_line_asm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hamsa_l0_line_asm                                            |
// | Description : Line assembly buffer. It holds BEATS x BEAT_W registers and  |
// |               writes one beat slot per response, selected by index.        |
// |               i_clr zeroes the whole line.                                 |
// | Ports       : clk, rst_n  - clock, async active-low reset                   |
// |               i_clr       - clear all beat slots                           |
// |               i_wr_en     - write i_wr_beat into slot i_wr_idx             |
// |               i_wr_idx    - beat slot index                                |
// |               i_wr_beat   - beat data                                      |
// |               o_line      - assembled line, beat k at [32k+31:32k]         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hamsa_l0_line_asm
   import hamsa_l0_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clr,
   input  logic                  i_wr_en,
   input  logic [BEAT_IDX_W-1:0] i_wr_idx,
   input  logic [BEAT_W-1:0]     i_wr_beat,
   output logic [LINE_W-1:0]     o_line
);

   genvar g;
   generate
      for (g = 0; g < BEATS; g++) begin : g_beat
         logic [BEAT_W-1:0] r_beat;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_beat <= '0;
            end else if (i_clr) begin
               r_beat <= '0;
            end else if (i_wr_en && (i_wr_idx == BEAT_IDX_W'(g))) begin
               r_beat <= i_wr_beat;
            end
         end

         assign o_line[g*BEAT_W +: BEAT_W] = r_beat;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/hamsa_l0_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hamsa_l0_refill_ctrl                                         |
// | Description : L0 line refill engine. It accepts one miss at a time and     |
// |               reads the 128b line as 4 x 32b beats over a req/gnt/rvalid   |
// |               port, with one beat outstanding at a time. It then writes    |
// |               the assembled line to the cache in a single cycle. When      |
// |               PREFETCH_EN is set, a next-line prefetch follows each demand |
// |               fill. A flush drains any in-flight beat and drops the line.  |
// |               A bus error drops the fill and pulses err_o.                 |
// | Ports       : clk, rst_n            - clock, async active-low reset         |
// |               miss_valid_i/addr_i   - fill request from fetch             |
// |               miss_ready_o          - request accepted on valid&&ready    |
// |               flush_i               - abort fill, discard data            |
// |               mem_req_o/addr_o      - beat read request / word address    |
// |               mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i - bus rsp   |
// |               wr_addr_o/data_o/enable_o - cache line write                |
// |               busy_o                - engine not idle                     |
// |               err_o                 - one-cycle fill-dropped pulse        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hamsa_l0_refill_ctrl
   import hamsa_l0_pkg::*;
#(
   parameter logic PREFETCH_EN = 1'b1
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               miss_valid_i,
   input  logic [31:0]        miss_addr_i,
   output logic               miss_ready_o,
   input  logic               flush_i,
   output logic               mem_req_o,
   output logic [31:0]        mem_addr_o,
   input  logic               mem_gnt_i,
   input  logic               mem_rvalid_i,
   input  logic [BEAT_W-1:0]  mem_rdata_i,
   input  logic               mem_err_i,
   output logic [31:0]        wr_addr_o,
   output logic [LINE_W-1:0]  wr_data_o,
   output logic               wr_enable_o,
   output logic               busy_o,
   output logic               err_o
);

   refill_state_e          r_state;
   refill_state_e          w_state_nxt;
   logic [31:0]            r_line_base;
   logic [BEAT_IDX_W-1:0]  r_beat_cnt;
   logic                   r_is_pf;
   logic                   r_drain_gnt;   // DRAIN: beat granted, only rvalid left
   logic                   r_err;

   logic                   w_accept;
   logic                   w_rsp;
   logic                   w_last_beat;

   assign miss_ready_o = (r_state == S_IDLE) && !flush_i;
   assign w_accept     = miss_valid_i && miss_ready_o;
   assign w_rsp        = (r_state == S_WAIT_R) && mem_rvalid_i;
   assign w_last_beat  = (r_beat_cnt == BEAT_IDX_W'(BEATS - 1));

   // mem_req_o depends only on state. A flush therefore never retracts a
   // request already on the bus; DRAIN holds it until it is granted.
   assign mem_req_o    = (r_state == S_REQ) || ((r_state == S_DRAIN) && !r_drain_gnt);
   assign mem_addr_o   = r_line_base + {{(32-BEAT_IDX_W-2){1'b0}}, r_beat_cnt, 2'b00};
   assign wr_enable_o  = (r_state == S_WRITE) && !flush_i;
   assign wr_addr_o    = r_line_base;
   assign busy_o       = (r_state != S_IDLE);
   assign err_o        = r_err;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (flush_i)        w_state_nxt = S_DRAIN;
            else if (mem_gnt_i) w_state_nxt = S_WAIT_R;
         end
         S_WAIT_R: begin
            if (mem_rvalid_i) begin
               if (flush_i || mem_err_i) w_state_nxt = S_IDLE;
               else if (w_last_beat)     w_state_nxt = S_WRITE;
               else                      w_state_nxt = S_REQ;
            end else if (flush_i) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_WRITE: begin
            if (!flush_i && PREFETCH_EN && !r_is_pf) w_state_nxt = S_PF_SETUP;
            else                                    w_state_nxt = S_IDLE;
         end
         S_PF_SETUP: begin
            w_state_nxt = flush_i ? S_IDLE : S_REQ;
         end
         S_DRAIN: begin
            // Responses arrive no earlier than the cycle after gnt.
            if (r_drain_gnt && mem_rvalid_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_line_base <= '0;
         r_beat_cnt  <= '0;
         r_is_pf     <= 1'b0;
         r_drain_gnt <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_rsp && mem_err_i;

         if (w_accept) begin
            r_line_base <= line_base_of(miss_addr_i);
            r_beat_cnt  <= '0;
            r_is_pf     <= 1'b0;
         end else if ((r_state == S_PF_SETUP) && !flush_i) begin
            r_line_base <= r_line_base + 32'd16;   // wraps mod 2^32
            r_beat_cnt  <= '0;
            r_is_pf     <= 1'b1;
         end else if (w_rsp && !flush_i && !mem_err_i && !w_last_beat) begin
            r_beat_cnt  <= r_beat_cnt + 1'b1;
         end

         // Track whether the beat being drained has already been granted.
         if ((r_state == S_REQ) && flush_i)
            r_drain_gnt <= mem_gnt_i;
         else if ((r_state == S_WAIT_R) && flush_i)
            r_drain_gnt <= 1'b1;
         else if ((r_state == S_DRAIN) && mem_gnt_i)
            r_drain_gnt <= 1'b1;
      end
   end

   hamsa_l0_line_asm u_line_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_accept),
      .i_wr_en   (w_rsp && !mem_err_i),
      .i_wr_idx  (r_beat_cnt),
      .i_wr_beat (mem_rdata_i),
      .o_line    (wr_data_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_hamsa_l0_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hamsa_l0_refill_ctrl                                      |
// | Description : Directed self-checking bench for hamsa_l0_refill_ctrl. A     |
// |               line-level model queues the expected beat addresses and     |
// |               cache writes. A bus responder with programmable delays acts |
// |               as memory.                                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hamsa_l0_refill_ctrl;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          miss_valid_i;
   logic [31:0]   miss_addr_i;
   logic          miss_ready_o;
   logic          flush_i;
   logic          mem_req_o;
   logic [31:0]   mem_addr_o;
   logic          mem_gnt_i;
   logic          mem_rvalid_i;
   logic [31:0]   mem_rdata_i;
   logic          mem_err_i;
   logic [31:0]   wr_addr_o;
   logic [127:0]  wr_data_o;
   logic          wr_enable_o;
   logic          busy_o;
   logic          err_o;

   always #5 clk = ~clk;

   hamsa_l0_refill_ctrl #(.PREFETCH_EN(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .miss_valid_i (miss_valid_i),
      .miss_addr_i  (miss_addr_i),
      .miss_ready_o (miss_ready_o),
      .flush_i      (flush_i),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .mem_err_i    (mem_err_i),
      .wr_addr_o    (wr_addr_o),
      .wr_data_o    (wr_data_o),
      .wr_enable_o  (wr_enable_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // ---------------- memory contents and line-level model ----------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a >= 32'h1230 && a <= 32'h123C) return 32'hA0 + ((a - 32'h1230) >> 2);
      return a ^ 32'h5A5A_0000;
   endfunction

   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
   } wr_t;

   logic [31:0] exp_bus_q[$];
   wr_t         exp_wr_q[$];
   int          exp_err = 0;

   task automatic expect_line(input logic [31:0] base);
      wr_t e;
      e.addr = base;
      e.data = '0;
      for (int k = 0; k < 4; k++) begin
         exp_bus_q.push_back(base + 32'(4*k));
         e.data[32*k +: 32] = mem_word(base + 32'(4*k));
      end
      exp_wr_q.push_back(e);
   endtask

   // Demand line followed by its next-line prefetch.
   task automatic expect_fill(input logic [31:0] miss_addr);
      logic [31:0] base;
      base = {miss_addr[31:4], 4'h0};
      expect_line(base);
      expect_line(base + 32'd16);
   endtask

   // ---------------- bus responder ----------------
   int          rv_dly  = 0;
   logic        gd_en   = 1'b0;
   logic [31:0] gd_addr = '0;
   int          gd_n    = 0;
   logic        err_en  = 1'b0;
   logic [31:0] err_addr = '0;

   initial begin
      logic        pend;
      logic [31:0] paddr;
      int          rcnt;
      int          wcnt;
      pend = 1'b0; paddr = '0; rcnt = 0; wcnt = 0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
         if (pend) begin
            if (rcnt == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = mem_word(paddr);
               mem_err_i    = err_en && (paddr == err_addr);
               pend         = 1'b0;
            end else begin
               rcnt--;
            end
         end else if (mem_req_o) begin
            if (gd_en && (mem_addr_o == gd_addr) && (wcnt < gd_n)) begin
               wcnt++;
            end else begin
               mem_gnt_i = 1'b1;
               pend      = 1'b1;
               paddr     = mem_addr_o;
               rcnt      = rv_dly;
               wcnt      = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare process ----------------
   int          n_req_cyc    = 0;
   int          last_wr_cyc  = -1;
   logic [31:0] last_wr_addr = '0;

   initial begin
      logic        prev_wait;
      logic [31:0] prev_addr;
      wr_t         e;
      prev_wait = 1'b0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_wait = 1'b0;
         end else begin
            check("ready_rule", miss_ready_o, !busy_o && !flush_i);
            if (mem_req_o) begin
               n_req_cyc++;
               if (prev_wait) check("addr_stable", mem_addr_o, prev_addr);
               if (mem_gnt_i) begin
                  if (exp_bus_q.size() == 0) fail_now("unexpected_beat");
                  else check("beat_addr", mem_addr_o, exp_bus_q.pop_front());
               end
            end else if (prev_wait) begin
               fail_now("req_retracted");
            end
            prev_wait = mem_req_o && !mem_gnt_i;
            prev_addr = mem_addr_o;
            if (wr_enable_o) begin
               last_wr_cyc  = cyc;
               last_wr_addr = wr_addr_o;
               if (exp_wr_q.size() == 0) begin
                  fail_now("unexpected_write");
               end else begin
                  e = exp_wr_q.pop_front();
                  check("wr_addr", wr_addr_o, e.addr);
                  check("wr_data", wr_data_o, e.data);
               end
            end
            if (err_o) begin
               check("err_expected", exp_err > 0, 1);
               if (exp_err > 0) exp_err--;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_miss(input logic [31:0] a, output int acc_cyc);
      miss_valid_i = 1'b1;
      miss_addr_i  = a;
      acc_cyc      = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (miss_ready_o) begin
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            miss_valid_i = 1'b0;
            return;
         end
      end
      miss_valid_i = 1'b0;
      fail_now("miss_accept_timeout");
   endtask

   task automatic wait_wr(output int wcyc);
      wcyc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (wr_enable_o) begin
            wcyc = cyc;
            return;
         end
      end
      fail_now("write_timeout");
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy_o && exp_bus_q.size() == 0 && exp_wr_q.size() == 0) return;
      end
      fail_now(name);
   endtask

   task automatic wait_gnt(input logic [31:0] a, output int gcyc);
      gcyc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (mem_req_o && mem_gnt_i && mem_addr_o == a) begin
            gcyc = cyc;
            return;
         end
      end
      fail_now("gnt_timeout");
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int   t0, cw, t1, g;
      logic saw_rv;

      rst_n = 1'b0; miss_valid_i = 1'b0; miss_addr_i = '0; flush_i = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_mem_req",  mem_req_o,    0);
      check("rst_mem_addr", mem_addr_o,   0);
      check("rst_wr_en",    wr_enable_o,  0);
      check("rst_wr_addr",  wr_addr_o,    0);
      check("rst_wr_data",  wr_data_o,    0);
      check("rst_busy",     busy_o,       0);
      check("rst_err",      err_o,        0);
      check("rst_ready",    miss_ready_o, 1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      // 1: demand fill, zero-wait memory
      expect_fill(32'h0000_1234);
      do_miss(32'h0000_1234, t0);
      wait_wr(cw);
      check("t1_latency", cw - t0, 9);
      check("t1_wr_addr", wr_addr_o, 32'h1230);
      check("t1_wr_data", wr_data_o, 128'h000000A3_000000A2_000000A1_000000A0);

      // 2: a miss during the prefetch waits for the prefetch write
      tick();
      expect_fill(32'h0000_2000);
      do_miss(32'h0000_2000, t1);
      check("t2_pf_wr_addr", last_wr_addr, 32'h1240);
      check("t2_accept_cyc", t1, cw + 11);
      check("t2_accept_after_pf", t1, last_wr_cyc + 1);
      wait_done("t2_done_timeout");

      // 3: beat 1 grant withheld for 3 cycles
      gd_en = 1'b1; gd_addr = 32'h1234; gd_n = 3;
      n_req_cyc = 0;
      expect_fill(32'h0000_1234);
      tick();
      do_miss(32'h0000_1234, t0);
      wait_done("t3_done_timeout");
      check("t3_req_cycles", n_req_cyc, 11);
      gd_en = 1'b0;

      // 4: flush one cycle after gnt of beat 2, rvalid two cycles later
      rv_dly = 2;
      exp_bus_q.push_back(32'h5000);
      exp_bus_q.push_back(32'h5004);
      exp_bus_q.push_back(32'h5008);
      tick();
      do_miss(32'h0000_5000, t0);
      wait_gnt(32'h5008, g);
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      saw_rv = 1'b0;
      for (int i = 0; i < 20 && !saw_rv; i++) begin
         @(negedge clk);
         if (mem_rvalid_i) saw_rv = 1'b1;
      end
      check("t4_rv_seen", saw_rv, 1);
      check("t4_busy_at_rv", busy_o, 1);
      @(negedge clk);
      check("t4_busy_after_rv", busy_o, 0);
      repeat (4) @(negedge clk);
      check("t4_beats_left", exp_bus_q.size(), 0);
      rv_dly = 0;

      // 5: bus error on beat 1
      err_en = 1'b1; err_addr = 32'h6004;
      exp_bus_q.push_back(32'h6000);
      exp_bus_q.push_back(32'h6004);
      exp_err = 1;
      tick();
      do_miss(32'h0000_6000, t0);
      saw_rv = 1'b0;
      for (int i = 0; i < 30 && !saw_rv; i++) begin
         @(negedge clk);
         if (mem_rvalid_i && mem_err_i) saw_rv = 1'b1;
      end
      check("t5_err_rsp_seen", saw_rv, 1);
      @(negedge clk);
      check("t5_err_pulse", err_o, 1);
      check("t5_ready_next", miss_ready_o, 1);
      check("t5_no_write", wr_enable_o, 0);
      @(negedge clk);
      check("t5_err_one_cycle", err_o, 0);
      check("t5_err_consumed", exp_err, 0);
      repeat (3) @(negedge clk);
      check("t5_no_prefetch", busy_o, 0);
      err_en = 1'b0;

      // 6a: prefetch line base wraps to 0
      expect_fill(32'hFFFF_FFF0);
      tick();
      do_miss(32'hFFFF_FFF0, t0);
      wait_done("t6_done_timeout");
      check("t6_wrap_wr_addr", last_wr_addr, 32'h0000_0000);

      // 6b: async reset while waiting for beat 0 response
      rv_dly = 4;
      exp_bus_q.push_back(32'h3000);
      tick();
      do_miss(32'h0000_3000, t0);
      wait_gnt(32'h3000, g);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t6_rst_mem_req",  mem_req_o,   0);
      check("t6_rst_mem_addr", mem_addr_o,  0);
      check("t6_rst_wr_en",    wr_enable_o, 0);
      check("t6_rst_wr_addr",  wr_addr_o,   0);
      check("t6_rst_wr_data",  wr_data_o,   0);
      check("t6_rst_busy",     busy_o,      0);
      check("t6_rst_err",      err_o,       0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      saw_rv = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (mem_rvalid_i) saw_rv = 1'b1;
         if (busy_o) fail_now("t6_busy_after_reset");
      end
      check("t6_late_rv_seen", saw_rv, 1);
      check("t6_late_rv_busy", busy_o, 0);
      check("t6_late_rv_data", wr_data_o, 0);
      rv_dly = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout");
      $fatal(1);
   end

endmodule
`default_nettype wire
